// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_job_sequencer
// Brief    : Accepts operand pairs, launches an external GCD datapath, waits
//            for a result or timeout, and returns it over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_job_sequencer #(
    parameter int BusSize      = 8,
    parameter int SettleCycles = 2,
    parameter int MaxCycles    = 600
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [BusSize-1:0] a_i,
    input  logic [BusSize-1:0] b_i,
    output logic [BusSize-1:0] core_a_o,
    output logic [BusSize-1:0] core_b_o,
    input  logic [BusSize-1:0] core_result_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BusSize-1:0] out_result_o,
    output logic               out_timeout_o,
    output logic               busy_o
);

    // Counter is shared by SETTLE and RUN, so size it for the larger limit.
    localparam int c_CNT_MAX = (MaxCycles > SettleCycles) ? MaxCycles : SettleCycles;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'((SettleCycles > 0) ? SettleCycles - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_RUN_LAST    = c_CNT_W'((MaxCycles > 0) ? MaxCycles - 1 : 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_RUN    = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [BusSize-1:0] r_a;
    logic [BusSize-1:0] r_b;
    logic [BusSize-1:0] r_result;
    logic               r_timeout;
    logic               w_zero_op;
    logic               w_core_done;

    assign w_zero_op   = (a_i == '0) || (b_i == '0);
    assign w_core_done = (core_result_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid_i) begin
                        r_a   <= a_i;
                        r_b   <= b_i;
                        r_cnt <= '0;
                        if (w_zero_op) begin
                            r_result  <= '0;
                            r_timeout <= 1'b0;
                            r_state   <= c_RESP;
                        end else if (SettleCycles == 0) begin
                            r_state <= c_RUN;
                        end else begin
                            r_state <= c_SETTLE;
                        end
                    end
                end
                c_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RUN: begin
                    if (r_cnt != c_RUN_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A real result wins over a timeout landing on the same cycle.
                    if (w_core_done) begin
                        r_result  <= core_result_i;
                        r_timeout <= 1'b0;
                        r_state   <= c_RESP;
                    end else if (r_cnt == c_RUN_LAST) begin
                        r_result  <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (out_ready_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready_o    = (r_state == c_IDLE);
    assign out_valid_o   = (r_state == c_RESP);
    assign busy_o        = (r_state != c_IDLE);
    assign core_a_o      = r_a;
    assign core_b_o      = r_b;
    assign out_result_o  = r_result;
    assign out_timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: doc/gcd_job_sequencer.md
GCD_JOB_SEQUENCER -- requirements
Module: gcd_job_sequencer

Interface
REQ-001 SHALL have parameter BusSize, default 8, operand and result width in bits.
REQ-002 SHALL have parameter SettleCycles, default 2, cycles after launch during which core_result_i is ignored.
REQ-003 SHALL have parameter MaxCycles, default 600, RUN-state cycle limit before timeout.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, ports clk_i and rst_ni.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 async active-low reset.
REQ-006 SHALL have ports: in_valid_i in 1 operand pair valid; in_ready_o out 1 sequencer can accept; a_i in BusSize operand A; b_i in BusSize operand B.
REQ-007 SHALL have ports: core_a_o out BusSize and core_b_o out BusSize, which drive the GCD datapath A_i/B_i; core_result_i in BusSize, which takes the datapath result_o.
REQ-008 SHALL have ports: out_valid_o out 1 result valid; out_ready_i in 1 consumer accepts; out_result_o out BusSize GCD result; out_timeout_o out 1 job timed out; busy_o out 1 job in flight (state != IDLE).

Function
REQ-009 SHALL implement states IDLE, SETTLE, RUN and RESP, all registered.
REQ-010 SHALL assert in_ready_o combinationally only in IDLE.
REQ-011 SHALL, in IDLE, accept a job on in_valid_i && in_ready_o and latch a_i and b_i into operand registers on that edge.
REQ-012 SHALL, on accept with a_i == 0 or b_i == 0, go directly to RESP with out_result_o = 0 and out_timeout_o = 0, so out_valid_o rises the cycle after accept.
REQ-013 SHALL, on accept with both operands nonzero, go to SETTLE and clear the cycle counter.
REQ-014 SHALL drive core_a_o and core_b_o from the operand registers in every state, holding them stable until the next accept.
REQ-015 SHALL stay in SETTLE for exactly SettleCycles cycles, ignoring core_result_i, then enter RUN with the counter cleared.
REQ-016 SHALL, in RUN, increment the counter every cycle; the counter is $clog2(MaxCycles+1) bits wide and never wraps.
REQ-017 SHALL, in RUN, when core_result_i != 0, capture it into out_result_o, clear out_timeout_o and enter RESP on the next edge.
REQ-018 SHALL, in RUN, when the counter equals MaxCycles-1 and core_result_i == 0, set out_result_o = 0, set out_timeout_o = 1 and enter RESP.
REQ-019 SHALL give a nonzero core_result_i priority over timeout when both occur in the same cycle.
REQ-020 SHALL assert out_valid_o only in RESP, and hold out_result_o and out_timeout_o stable while out_valid_o && !out_ready_i.
REQ-021 SHALL, on out_valid_o && out_ready_i, return to IDLE; out_valid_o deasserts and in_ready_o asserts the following cycle, with no same-cycle accept in RESP.
REQ-022 SHALL ignore in_valid_i, a_i and b_i outside IDLE.

Reset
REQ-023 SHALL, on rst_ni low at any time including mid-job, immediately force state IDLE and abandon the job.
REQ-024 SHALL, on reset, clear the counter, the operand registers and out_result_o, and set core_a_o, core_b_o, out_valid_o, out_timeout_o and busy_o to 0.
REQ-025 SHALL assert in_ready_o = 1 in the first cycle after rst_ni deasserts.

Verification
REQ-026 SHALL be verified with the real datapath (BusSize=8) by sending a=12, b=18 -> one response with out_result_o=6, out_timeout_o=0.
REQ-027 SHALL be verified by sending a=0, b=5 -> out_valid_o=1 one cycle after accept, out_result_o=0, out_timeout_o=0, core result ignored.
REQ-028 SHALL be verified by sending a=35, b=14 with out_ready_i held low 5 cycles after out_valid_o -> out_result_o=7 held stable all 5 cycles, in_ready_o=0 throughout.
REQ-029 SHALL be verified with a stub core holding result 0, MaxCycles=16 and SettleCycles=2 -> out_valid_o exactly 18 cycles after accept, out_timeout_o=1, out_result_o=0.
REQ-030 SHALL be verified by asserting rst_ni low for 1 cycle during RUN -> all outputs 0 immediately, in_ready_o=1 after release, next job a=9, b=6 -> 3.
REQ-031 SHALL be verified with a stub core raising result 4 on the same cycle the counter hits MaxCycles-1 -> out_result_o=4, out_timeout_o=0.
